div_result_fmt: RTL

DIV_RESULT_FMT -- requirements
Module: div_result_fmt

---
 rtl/div_fmt_pkg.sv | 15 +
 rtl/bcd_dabble_step.sv | 21 ++
 rtl/div_result_fmt.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/div_fmt_pkg.sv
// Shared types and constants for the divider result formatter.
package div_fmt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Digit shown on every position when the divider reports divide-by-zero
    localparam logic [3:0] ERR_DIGIT   = 4'hE;
    // Display code that blanks a leading-zero tens digit
    localparam logic [3:0] BLANK_DIGIT = 4'hF;

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble step on a two-digit BCD scratch: correct each digit
// that is 5 or more by adding 3, then shift left and insert the next operand bit.
module bcd_dabble_step (
    input  logic [7:0] bcd_in,
    input  logic       bit_in,
    output logic [7:0] bcd_out
);

    function automatic logic [3:0] adjust(input logic [3:0] d);
        adjust = (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    logic [7:0] adj;

    // Correct both digits, then shift the new bit in at the bottom
    always_comb begin
        adj     = {adjust(bcd_in[7:4]), adjust(bcd_in[3:0])};
        bcd_out = {adj[6:0], bit_in};
    end

endmodule

// File: rtl/div_result_fmt.sv
// Converts a divider's quotient/remainder into two-digit BCD for display.
// A rising edge of done starts a W-cycle double-dabble conversion; the
// digits are then held with valid=1 until the consumer acks.
// Optional build macro DIV_FMT_BLANK_EN: a zero tens digit is shown as the
// blank code instead of 0.
module div_result_fmt
    import div_fmt_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         done,
    input  logic         error,
    input  logic [W-1:0] quotient,
    input  logic [W-1:0] remainder,
    input  logic         ack,
    output logic [3:0]   q_hi,
    output logic [3:0]   q_lo,
    output logic [3:0]   r_hi,
    output logic [3:0]   r_lo,
    output logic         err_out,
    output logic         valid,
    output logic         busy,
    output logic         ovr
);

    localparam int CW = $clog2(W + 1);

    state_t        state, state_nx;
    logic          done_d;
    logic          trig;
    logic [W-1:0]  q_sh, r_sh;
    logic [7:0]    q_bcd, r_bcd;
    logic [7:0]    q_bcd_nx, r_bcd_nx;
    logic [CW-1:0] cnt;
    logic          last_step;

    // Tens digit formatting applied when results enter HOLD
    function automatic logic [3:0] tens_fmt(input logic [3:0] d);
`ifdef DIV_FMT_BLANK_EN
        tens_fmt = (d == 4'd0) ? BLANK_DIGIT : d;
`else
        tens_fmt = d;
`endif
    endfunction

    assign trig      = done & ~done_d;
    assign last_step = (cnt == CW'(1));
    assign busy      = (state == SHIFT);
    assign valid     = (state == HOLD);

    bcd_dabble_step u_q_step (
        .bcd_in  (q_bcd),
        .bit_in  (q_sh[W-1]),
        .bcd_out (q_bcd_nx)
    );

    bcd_dabble_step u_r_step (
        .bcd_in  (r_bcd),
        .bit_in  (r_sh[W-1]),
        .bcd_out (r_bcd_nx)
    );

    // Next-state logic: start on a done edge, finish after W steps, leave HOLD on ack
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (trig) state_nx = error ? HOLD : SHIFT;
            SHIFT:   if (last_step) state_nx = HOLD;
            HOLD:    if (ack) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register and done edge tracking
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            done_d <= 1'b0;
        end else begin
            state  <= state_nx;
            done_d <= done;
        end
    end

    // Operand capture, conversion steps, digit loading and sticky overrun
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_sh    <= '0;
            r_sh    <= '0;
            q_bcd   <= '0;
            r_bcd   <= '0;
            cnt     <= '0;
            q_hi    <= '0;
            q_lo    <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            err_out <= 1'b0;
            ovr     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (trig) begin
                        if (error) begin
                            q_hi    <= ERR_DIGIT;
                            q_lo    <= ERR_DIGIT;
                            r_hi    <= ERR_DIGIT;
                            r_lo    <= ERR_DIGIT;
                            err_out <= 1'b1;
                        end else begin
                            q_sh  <= quotient;
                            r_sh  <= remainder;
                            q_bcd <= '0;
                            r_bcd <= '0;
                            cnt   <= CW'(W);
                        end
                    end
                end
                SHIFT: begin
                    q_sh  <= q_sh << 1;
                    r_sh  <= r_sh << 1;
                    q_bcd <= q_bcd_nx;
                    r_bcd <= r_bcd_nx;
                    cnt   <= cnt - 1'b1;
                    if (last_step) begin
                        q_hi    <= tens_fmt(q_bcd_nx[7:4]);
                        q_lo    <= q_bcd_nx[3:0];
                        r_hi    <= tens_fmt(r_bcd_nx[7:4]);
                        r_lo    <= r_bcd_nx[3:0];
                        err_out <= 1'b0;
                    end
                    if (trig) ovr <= 1'b1;
                end
                HOLD: begin
                    if (trig) ovr <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
